// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Optional feature macro: SEQ_MULT_EARLY_TERM_EN (used in seq_multiplier.sv).
package seq_mult_pkg;

    // Widest value the helpers operate on; products up to 64 bits (N <= 32).
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width: clog2(N/K), at least one bit.
    function automatic int cnt_width(input int n, input int k);
        int c;
        c = $clog2(n / k);
        return (c < 1) ? 1 : c;
    endfunction

    // Mask keeping the low w bits of a MAX_W-bit value.
    function automatic logic [MAX_W-1:0] width_mask(input int w);
        if (w >= MAX_W) begin
            return '1;
        end
        return (MAX_W'(1) << w) - MAX_W'(1);
    endfunction

    // Magnitude of a w-bit operand; two's-complement when sgn is set.
    // The most negative value maps to 2^(w-1), which still fits in w bits.
    function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] x,
                                                 input int w,
                                                 input logic sgn);
        if (sgn && x[w-1]) begin
            return (~x + MAX_W'(1)) & width_mask(w);
        end
        return x & width_mask(w);
    endfunction

    // Two's-complement negation of a w-bit value, modulo 2^w.
    function automatic logic [MAX_W-1:0] negate(input logic [MAX_W-1:0] x,
                                                input int w);
        return (~x + MAX_W'(1)) & width_mask(w);
    endfunction

endpackage

// File: rtl/seq_mult_step.sv
// One shift-add iteration: adds mcand times a K-bit multiplier chunk
// into the running accumulator, modulo 2^(2N).
module seq_mult_step
    import seq_mult_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 1
) (
    input  logic [2*N-1:0] acc,
    input  logic [2*N-1:0] mcand,
    input  logic [K-1:0]   chunk,
    output logic [2*N-1:0] sum
);

    // Partial product of this chunk added to the accumulator.
    always_comb begin
        sum = acc + mcand * (2*N)'(chunk);
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier retiring K multiplier bits per clock,
// signed or unsigned per transaction, valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready is high only in IDLE, out_valid only in DONE, and the
// product is held stable until the out_valid&out_ready edge.
// Optional macro SEQ_MULT_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all zero.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int            STEPS = N / K;
    localparam int            CW    = cnt_width(N, K);
    localparam logic [CW-1:0] LAST  = CW'(STEPS - 1);

    if (N < 2 || 2 * N > MAX_W) begin : g_bad_n
        $error("seq_multiplier: N must be in 2..32");
    end
    if (K < 1 || (N % K) != 0) begin : g_bad_k
        $error("seq_multiplier: K must be positive and divide N");
    end

    state_t         state;
    logic [2*N-1:0] mcand;
    logic [2*N-1:0] acc;
    logic [N-1:0]   mplier;
    logic           neg;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] acc_next;
    logic           last_step;

    seq_mult_step #(
        .N(N),
        .K(K)
    ) u_step (
        .acc  (acc),
        .mcand(mcand),
        .chunk(mplier[K-1:0]),
        .sum  (acc_next)
    );

`ifdef SEQ_MULT_EARLY_TERM_EN
    // Stop after the final iteration or once no multiplier bits remain.
    always_comb begin
        last_step = (cnt == LAST) || ((mplier >> K) == '0);
    end
`else
    // Stop after the fixed number of iterations.
    always_comb begin
        last_step = (cnt == LAST);
    end
`endif

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mcand    <= (2*N)'(abs_mag(MAX_W'(a), N, is_signed));
                        mplier   <= N'(abs_mag(MAX_W'(b), N, is_signed));
                        neg      <= is_signed & (a[N-1] ^ b[N-1]);
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << K;
                    mplier <= mplier >> K;
                    cnt    <= cnt + CW'(1);
                    if (last_step) begin
                        product   <= (2*N)'(neg ? negate(MAX_W'(acc_next), 2 * N)
                                                : MAX_W'(acc_next));
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: two instances (N=8 with K=1 and K=2) exercised
// one at a time, checked by a scoreboard monitor fed from expected queues.
module tb_seq_multiplier;

    logic        clk;
    logic        rst_n = 1'b1;
    logic        in_valid_v [2];
    logic        in_ready_v [2];
    logic [7:0]  a_v        [2];
    logic [7:0]  b_v        [2];
    logic        is_signed_v[2];
    logic        out_valid_v[2];
    logic        out_ready_v[2];
    logic [15:0] product_v  [2];
    logic        busy_v     [2];

    logic [15:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_ov[2];
    logic rand_rdy = 1'b0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    seq_multiplier #(.N(8), .K(1)) u_dut_k1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0]), .b(b_v[0]), .is_signed(is_signed_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .product(product_v[0]), .busy(busy_v[0])
    );

    seq_multiplier #(.N(8), .K(2)) u_dut_k2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1]), .b(b_v[1]), .is_signed(is_signed_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .product(product_v[1]), .busy(busy_v[1])
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycles from accept to out_valid for multiplier b on an N=8 instance.
    function automatic int exp_lat(input logic [7:0] bv, input logic s, input int k);
`ifdef SEQ_MULT_EARLY_TERM_EN
        logic [7:0] m;
        int h;
        int l;
        m = (s && bv[7]) ? (~bv + 8'd1) : bv;
        h = -1;
        for (int i = 0; i < 8; i++) if (m[i]) h = i;
        l = (h + 1 + k - 1) / k;
        return (l < 1) ? 1 : l;
`else
        if (bv[0] === 1'bx || s === 1'bx) return 0;
        return 8 / k;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input int d, input logic [7:0] av, input logic [7:0] bv,
                         input logic s, input logic [15:0] ep, input logic track);
        int n;
        @(negedge clk);
        in_valid_v[d]  = 1'b1;
        a_v[d]         = av;
        b_v[d]         = bv;
        is_signed_v[d] = s;
        n = 0;
        while (!in_ready_v[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_v[d]) begin
            check("accept_timeout", 16'(in_ready_v[d]), 16'd1);
            in_valid_v[d] = 1'b0;
            return;
        end
        if (track) begin
            exp_q.push_back(ep);
            lat_q.push_back(exp_lat(bv, s, (d == 0) ? 1 : 2));
            acc_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        in_valid_v[d]  = 1'b0;
        a_v[d]         = 8'($urandom_range(0, 255));
        b_v[d]         = 8'($urandom_range(0, 255));
        is_signed_v[d] = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || lat_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || lat_q.size() != 0) begin
            check("drain_timeout", 16'(exp_q.size() + lat_q.size()), 16'd0);
            exp_q.delete();
            lat_q.delete();
            acc_q.delete();
        end
    endtask

    // Random backpressure for the K=2 instance, driven away from the sampling edge.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #2;
            out_ready_v[1] = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        int l;
        int ac;
        for (int d = 0; d < 2; d++) begin
            if (rst_n && out_valid_v[d]) begin
                if (!prev_ov[d]) begin
                    if (lat_q.size() == 0) begin
                        check("unexpected_valid", 16'd1, 16'd0);
                    end else begin
                        l  = lat_q.pop_front();
                        ac = acc_q.pop_front();
                        check("latency", 16'(cyc - ac), 16'(l));
                    end
                end
                if (out_ready_v[d]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_product", product_v[d], 16'd0);
                    end else begin
                        check("product", product_v[d], exp_q.pop_front());
                    end
                end
            end
            prev_ov[d] = out_valid_v[d];
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            in_valid_v[d]  = 1'b0;
            a_v[d]         = 8'h00;
            b_v[d]         = 8'h00;
            is_signed_v[d] = 1'b0;
            out_ready_v[d] = 1'b1;
            prev_ov[d]     = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_in_ready", 16'(in_ready_v[d]), 16'd1);
            check("rst_out_valid", 16'(out_valid_v[d]), 16'd0);
            check("rst_product", product_v[d], 16'd0);
            check("rst_busy", 16'(busy_v[d]), 16'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // K=1 directed vectors: unsigned then signed.
        issue(0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
        issue(0, 8'h03, 8'h05, 1'b0, 16'h000F, 1'b1);
        issue(0, 8'h7F, 8'h01, 1'b0, 16'h007F, 1'b1);
        issue(0, 8'h55, 8'h00, 1'b0, 16'h0000, 1'b1);
        issue(0, 8'h12, 8'h80, 1'b0, 16'h0900, 1'b1);
        issue(0, 8'h80, 8'h80, 1'b0, 16'h4000, 1'b1);
        issue(0, 8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b1);
        issue(0, 8'h7F, 8'h81, 1'b1, 16'hC0FF, 1'b1);
        issue(0, 8'h80, 8'h02, 1'b1, 16'hFF00, 1'b1);
        issue(0, 8'h05, 8'hFD, 1'b1, 16'hFFF1, 1'b1);
        drain();

        // Backpressure: result held in DONE, new operands ignored.
        out_ready_v[0] = 1'b0;
        issue(0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
        n = 0;
        while (!out_valid_v[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_reach_done", 16'(out_valid_v[0]), 16'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_product", product_v[0], 16'hFE01);
            check("bp_in_ready", 16'(in_ready_v[0]), 16'd0);
            check("bp_out_valid", 16'(out_valid_v[0]), 16'd1);
            in_valid_v[0] = (i % 2 == 0);
            a_v[0] = 8'h01;
            b_v[0] = 8'h01;
        end
        @(posedge clk);
        #1;
        in_valid_v[0]  = 1'b0;
        out_ready_v[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_after_valid", 16'(out_valid_v[0]), 16'd0);
        check("bp_after_in_ready", 16'(in_ready_v[0]), 16'd1);
        check("bp_after_busy", 16'(busy_v[0]), 16'd0);
        drain();

        // Asynchronous reset in the middle of a run.
        issue(0, 8'h21, 8'h43, 1'b0, 16'h0000, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        check("mid_busy", 16'(busy_v[0]), 16'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 16'(out_valid_v[0]), 16'd0);
        check("mid_rst_product", product_v[0], 16'd0);
        check("mid_rst_in_ready", 16'(in_ready_v[0]), 16'd1);
        check("mid_rst_busy", 16'(busy_v[0]), 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 8'h03, 8'h05, 1'b0, 16'h000F, 1'b1);
        drain();

        // K=2 directed vectors under random backpressure.
        rand_rdy = 1'b1;
        issue(1, 8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
        issue(1, 8'h80, 8'h7F, 1'b1, 16'hC080, 1'b1);
        issue(1, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
        issue(1, 8'h0D, 8'h0B, 1'b0, 16'h008F, 1'b1);
        issue(1, 8'hF6, 8'h06, 1'b1, 16'hFFC4, 1'b1);
        issue(1, 8'hAA, 8'h00, 1'b0, 16'h0000, 1'b1);
        issue(1, 8'h00, 8'h80, 1'b1, 16'h0000, 1'b1);
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #3;
        out_ready_v[1] = 1'b1;

        repeat (20) @(negedge clk);
        check("leftover_expect", 16'(lat_q.size() + exp_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard against a stuck run.
    initial begin
        #200000;
        bad++;
        total++;
        $display("FAIL global_timeout: simulation did not finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
